// File: rtl/bcd_display_scan.sv
// Four-slot multiplexed seven-segment driver for a two-digit BCD counter.
// Slots: ones, tens, blank, direction glyph; digit values are frozen per frame.
module bcd_display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       carry_in,
  input  logic       up,
  input  logic       blank_zero,
  input  logic       ovf_clear,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  localparam logic [1:0] SEL_ONES  = 2'd0;
  localparam logic [1:0] SEL_TENS  = 2'd1;
  localparam logic [1:0] SEL_BLANK = 2'd2;
  localparam logic [1:0] SEL_DIR   = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_UP    = 7'b1000001;
  localparam logic [6:0] SEG_DOWN  = 7'b0100001;

  logic [DIV_W-1:0] div;
  logic [1:0]       sel;
  logic [3:0]       snap_tens;
  logic [3:0]       snap_ones;
  logic             snap_up;
  logic             snap_ovf;
  logic             frame_start;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      div <= '0;
      sel <= SEL_ONES;
    end else if (div == DIV_LAST) begin
      div <= '0;
      sel <= sel + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign frame_start = (div == '0) && (sel == SEL_ONES);

  // The overflow snapshot takes the pre-edge flag, so a carry reaches dp one frame later.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      snap_tens <= '0;
      snap_ones <= '0;
      snap_up   <= 1'b0;
      snap_ovf  <= 1'b0;
    end else if (frame_start) begin
      snap_tens <= tens;
      snap_ones <= ones;
      snap_up   <= up;
      snap_ovf  <= overflow;
    end
  end

  // Set has priority over clear so a carry coinciding with a clear is not lost.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)        overflow <= 1'b0;
    else if (carry_in)   overflow <= 1'b1;
    else if (ovf_clear)  overflow <= 1'b0;
  end

  // NOTE: defaults first so no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (sel)
      SEL_ONES: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(snap_ones);
      end
      SEL_TENS: begin
        if (!(blank_zero && (snap_tens == 4'd0))) begin
          an_d  = 4'b1101;
          seg_d = seg_decode(snap_tens);
          dp_d  = ~snap_ovf;
        end
      end
      SEL_DIR: begin
        an_d  = 4'b0111;
        seg_d = snap_up ? SEG_UP : SEG_DOWN;
      end
      default: ;
    endcase
  end

  // Registering all three together keeps slot changes glitch-free.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed seven-segment driver that sits directly downstream of the two-digit BCD counter. It takes the counter's tens/ones digits, its carry pulse and the count direction, and scans them onto a 4-digit common-anode display. Digit values are snapshotted once per scan frame so the display never tears mid-frame. It also holds a sticky overflow flag that is shown on the decimal point.

## Interface

Parameters:
- SCAN_DIV, 100000, clock cycles per digit slot; legal range 2..2^20.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- tens  in  4  BCD tens digit from the counter.
- ones  in  4  BCD ones digit from the counter.
- carry_in  in  1  counter carry/borrow pulse, sampled every edge.
- up  in  1  count direction: 1 = up, 0 = down.
- blank_zero  in  1  1 = blank the tens digit when it is 0.
- ovf_clear  in  1  synchronous clear of the sticky overflow flag.
- an  out  4  digit anodes, active low; an[0] is the ones digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- overflow  out  1  sticky overflow flag, active high.

## Operation

Divider and slot select:
- div counts 0..SCAN_DIV-1 and wraps.
- sel (2 bits) increments when div == SCAN_DIV-1 and wraps 3 -> 0.

Snapshot:
- On each edge where div == 0 and sel == 0, load {tens, ones, up, overflow} into snapshot registers.
- Inputs that change at any other time have no effect until the next frame.

Overflow flag:
- Set on any edge where carry_in = 1.
- Cleared on any edge where ovf_clear = 1.
- When both are 1 on the same edge, set wins.

Output stage (registered; decoded from the current sel and snapshot):
- sel 0: an = 1110, seg = decode(ones), dp = 1.
- sel 1: an = 1101, seg = decode(tens), dp = 0 if snapshot overflow = 1, else 1.
  - If blank_zero = 1 and snapshot tens = 0: an = 1111, seg = 1111111, dp = 1.
- sel 2: an = 1111, seg = 1111111, dp = 1 (blank slot, kept so all digits get equal duty cycle).
- sel 3: an = 0111, seg = 1000001 ('U') if snapshot up = 1, else 0100001 ('d'); dp = 1.

Decode (seg values):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Non-BCD values 10..15 decode to '-' = 0111111.

blank_zero is used live by the output stage, not snapshotted.

## Timing

Reset (clear_n low, asynchronous):
- div = 0, sel = 0, all snapshots = 0, overflow = 0.
- an = 1111, seg = 1111111, dp = 1.

First edges after reset release:
- Edge 1: snapshot loads the inputs. The output stage shows slot 0 with the old snapshot, so an = 1110 and seg = 1000000 ('0').
- Edge 2 onward: outputs reflect the new snapshot.

Steady state:
- Outputs lag sel by 1 cycle.
- Each slot lasts exactly SCAN_DIV cycles; a frame lasts 4*SCAN_DIV cycles.
- Slot changes are glitch-free: an, seg and dp update on the same edge.

overflow output timing:
- Goes high the edge after a carry_in sample.
- Reaches dp only after the next frame snapshot.

Reset asserted mid-frame forces all reset values immediately, independent of clock.

## Test plan

- Reset check, SCAN_DIV = 4: hold clear_n = 0 -> an = 1111, seg = 1111111, dp = 1, overflow = 0. Release clear_n -> edge 1 gives an = 1110 and seg = 1000000.
- Frame sweep, SCAN_DIV = 4, tens = 4, ones = 7, up = 1, blank_zero = 0:
  - Expected per 4-cycle slot: an 1110/seg 1111000, then 1101/0011001, then 1111/1111111, then 0111/1000001.
  - Then it repeats with period 16.
- Snapshot stability: change ones from 7 to 2 while sel = 2 -> the slot-0 display still shows 7 until the next frame begins, then shows 0100100.
- Blanking and direction: tens = 0, blank_zero = 1, up = 0 -> the sel 1 slot has an = 1111, and the sel 3 slot shows seg = 0100001.
  - Set blank_zero = 0 -> the tens slot shows an = 1101, seg = 1000000.
- Overflow:
  - Pulse carry_in for 1 cycle -> overflow = 1 on the next edge; dp = 0 during the tens slot from the next frame on.
  - Assert carry_in and ovf_clear on the same edge -> overflow stays 1.
  - Then ovf_clear alone -> overflow = 0.
- Invalid BCD plus mid-frame reset: ones = 12 -> slot 0 shows seg = 0111111. Pulling clear_n low at sel = 2 immediately forces an = 1111, and sel restarts at 0 after release.
